// File: rtl/mem_pkg.sv
// Shared definitions for the MEM pipeline stage: memory sub-op codes,
// FSM state encoding, access sizes and big-endian byte-lane constants.
package mem_pkg;

    // Memory sub-op codes carried on ALU_Control
    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2B;

    // Transaction FSM states
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_e;

    // Access width decoded from the sub-op
    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } mem_size_e;

    // Big-endian lane masks at offset 0 (bit 3 = byte at offset 0)
    localparam logic [3:0] LANE_BE_BYTE = 4'b1000;
    localparam logic [3:0] LANE_BE_HALF = 4'b1100;
    localparam logic [3:0] LANE_BE_WORD = 4'b1111;

    // Map unknown codes onto LW/SW so every memory access has a defined size
    function automatic logic [5:0] norm_sub_op(input logic [5:0] code,
                                               input logic       rd,
                                               input logic       wr);
        logic [5:0] op;
        op = code;
        if (wr) begin
            if (!(code == OP_SB || code == OP_SH || code == OP_SW)) begin
                op = OP_SW;
            end else begin
                op = code;
            end
        end else if (rd) begin
            if (!(code == OP_LB || code == OP_LH || code == OP_LW ||
                  code == OP_LBU || code == OP_LHU)) begin
                op = OP_LW;
            end else begin
                op = code;
            end
        end else begin
            op = code;
        end
        return op;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane logic for the MEM stage: store byte enables and
// data replication, load lane extraction with extension, and the
// alignment check. Big-endian: offset 0 is bits [31:24].
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [5:0]  sub_op,
    input  logic [1:0]  off,
    input  logic [31:0] st_data,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] ld_data,
    output logic        misaligned
);

    mem_size_e   size_s;
    logic        sign_s;
    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Decode access width and signedness from the normalised sub-op
    always_comb begin
        size_s = SZ_WORD;
        sign_s = 1'b0;
        case (sub_op)
            OP_LB:         begin size_s = SZ_BYTE; sign_s = 1'b1; end
            OP_LBU, OP_SB: begin size_s = SZ_BYTE; sign_s = 1'b0; end
            OP_LH:         begin size_s = SZ_HALF; sign_s = 1'b1; end
            OP_LHU, OP_SH: begin size_s = SZ_HALF; sign_s = 1'b0; end
            default:       begin size_s = SZ_WORD; sign_s = 1'b0; end
        endcase
    end

    // Bytes are always aligned; halves need an even offset; words offset 0
    always_comb begin
        misaligned = 1'b0;
        case (size_s)
            SZ_BYTE: misaligned = 1'b0;
            SZ_HALF: misaligned = off[0];
            default: misaligned = (off != 2'b00);
        endcase
    end

    // Store side: lane enables and replicated write data
    always_comb begin
        be    = LANE_BE_WORD;
        wdata = st_data;
        case (size_s)
            SZ_BYTE: begin
                be    = LANE_BE_BYTE >> off;
                wdata = {4{st_data[7:0]}};
            end
            SZ_HALF: begin
                be    = LANE_BE_HALF >> off;
                wdata = {2{st_data[15:0]}};
            end
            default: begin
                be    = LANE_BE_WORD;
                wdata = st_data;
            end
        endcase
    end

    // Load side: pick the addressed lane and extend to 32 bits
    always_comb begin
        byte_s  = 8'h00;
        half_s  = 16'h0000;
        ld_data = rdata;
        case (off)
            2'd0:    byte_s = rdata[31:24];
            2'd1:    byte_s = rdata[23:16];
            2'd2:    byte_s = rdata[15:8];
            default: byte_s = rdata[7:0];
        endcase
        if (off[1]) begin
            half_s = rdata[15:0];
        end else begin
            half_s = rdata[31:16];
        end
        case (size_s)
            SZ_BYTE: ld_data = {{24{sign_s & byte_s[7]}}, byte_s};
            SZ_HALF: ld_data = {{16{sign_s & half_s[15]}}, half_s};
            default: ld_data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage. Non-memory results pass to WB in one cycle. Legal
// loads/stores run one req/ack transaction with the data memory while the
// upstream pipeline is stalled; misaligned or contradictory accesses are
// dropped with a one-cycle AddrErr pulse.
module mem_stage
    import mem_pkg::*;
(
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] Instr1_IN,
    input  logic [31:0] Instr1_PC_IN,
    input  logic [31:0] ALU_result1_IN,
    input  logic [4:0]  WriteRegister1_IN,
    input  logic [31:0] MemWriteData1_IN,
    input  logic        RegWrite1_IN,
    input  logic        MemRead1_IN,
    input  logic        MemWrite1_IN,
    input  logic [5:0]  ALU_Control1_IN,
    output logic        Stall_OUT,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic [31:0] Instr1_OUT,
    output logic [31:0] Instr1_PC_OUT,
    output logic [31:0] WriteData1_OUT,
    output logic [4:0]  WriteRegister1_OUT,
    output logic        RegWrite1_OUT,
    output logic        AddrErr_OUT
);

    // FSM and memory interface registers
    mem_state_e  state_q, state_d;
    logic        dmem_req_q, dmem_req_d;
    logic        dmem_we_q, dmem_we_d;
    logic [31:0] dmem_addr_q, dmem_addr_d;
    logic [31:0] dmem_wdata_q, dmem_wdata_d;
    logic [3:0]  dmem_be_q, dmem_be_d;

    // Instruction context held for the duration of a transaction
    logic [5:0]  op_q, op_d;
    logic [1:0]  off_q, off_d;
    logic        is_load_q, is_load_d;
    logic        rw_lat_q, rw_lat_d;
    logic [4:0]  wreg_lat_q, wreg_lat_d;
    logic [31:0] instr_lat_q, instr_lat_d;
    logic [31:0] pc_lat_q, pc_lat_d;

    // WB output registers
    logic [31:0] instr_out_q, instr_out_d;
    logic [31:0] pc_out_q, pc_out_d;
    logic [31:0] wdata_out_q, wdata_out_d;
    logic [4:0]  wreg_out_q, wreg_out_d;
    logic        rw_out_q, rw_out_d;
    logic        addrerr_q, addrerr_d;

    // Decode of the incoming instruction
    logic        mem_op_s;
    logic        both_s;
    logic        legal_s;
    logic        err_s;
    logic [5:0]  live_op_s;
    logic [5:0]  align_op_s;
    logic [1:0]  align_off_s;
    logic [3:0]  be_s;
    logic [31:0] wdata_s;
    logic [31:0] ld_data_s;
    logic        misaligned_s;

    assign mem_op_s  = MemRead1_IN | MemWrite1_IN;
    assign both_s    = MemRead1_IN & MemWrite1_IN;
    assign live_op_s = norm_sub_op(ALU_Control1_IN, MemRead1_IN, MemWrite1_IN);

    // One lane aligner serves both phases: issue uses the live instruction,
    // completion uses the context captured at issue.
    assign align_op_s  = (state_q == WAIT) ? op_q  : live_op_s;
    assign align_off_s = (state_q == WAIT) ? off_q : ALU_result1_IN[1:0];

    mem_lane_align u_align (
        .sub_op     (align_op_s),
        .off        (align_off_s),
        .st_data    (MemWriteData1_IN),
        .rdata      (dmem_rdata),
        .be         (be_s),
        .wdata      (wdata_s),
        .ld_data    (ld_data_s),
        .misaligned (misaligned_s)
    );

    assign legal_s = mem_op_s & ~both_s & ~misaligned_s;
    assign err_s   = mem_op_s & (both_s | misaligned_s);

    // Stall while a legal access is issuing or awaiting ack; forced low in reset
    assign Stall_OUT = RESET & (((state_q == IDLE) & legal_s) |
                                ((state_q == WAIT) & ~dmem_ack));

    // Next-state, memory request and WB output computation
    always_comb begin
        state_d      = state_q;
        dmem_req_d   = dmem_req_q;
        dmem_we_d    = dmem_we_q;
        dmem_addr_d  = dmem_addr_q;
        dmem_wdata_d = dmem_wdata_q;
        dmem_be_d    = dmem_be_q;
        op_d         = op_q;
        off_d        = off_q;
        is_load_d    = is_load_q;
        rw_lat_d     = rw_lat_q;
        wreg_lat_d   = wreg_lat_q;
        instr_lat_d  = instr_lat_q;
        pc_lat_d     = pc_lat_q;
        // Bubble unless a branch below produces a real result
        instr_out_d  = 32'h0000_0000;
        pc_out_d     = 32'h0000_0000;
        wdata_out_d  = 32'h0000_0000;
        wreg_out_d   = 5'd0;
        rw_out_d     = 1'b0;
        addrerr_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (legal_s) begin
                    state_d      = WAIT;
                    dmem_req_d   = 1'b1;
                    dmem_we_d    = MemWrite1_IN;
                    dmem_addr_d  = {ALU_result1_IN[31:2], 2'b00};
                    dmem_wdata_d = MemWrite1_IN ? wdata_s : 32'h0000_0000;
                    dmem_be_d    = be_s;
                    op_d         = live_op_s;
                    off_d        = ALU_result1_IN[1:0];
                    is_load_d    = MemRead1_IN;
                    rw_lat_d     = RegWrite1_IN;
                    wreg_lat_d   = WriteRegister1_IN;
                    instr_lat_d  = Instr1_IN;
                    pc_lat_d     = Instr1_PC_IN;
                end else if (err_s) begin
                    instr_out_d = Instr1_IN;
                    pc_out_d    = Instr1_PC_IN;
                    wdata_out_d = ALU_result1_IN;
                    wreg_out_d  = WriteRegister1_IN;
                    rw_out_d    = 1'b0;
                    addrerr_d   = 1'b1;
                end else begin
                    instr_out_d = Instr1_IN;
                    pc_out_d    = Instr1_PC_IN;
                    wdata_out_d = ALU_result1_IN;
                    wreg_out_d  = WriteRegister1_IN;
                    rw_out_d    = RegWrite1_IN;
                end
            end
            WAIT: begin
                if (dmem_ack) begin
                    state_d      = IDLE;
                    dmem_req_d   = 1'b0;
                    dmem_we_d    = 1'b0;
                    dmem_addr_d  = 32'h0000_0000;
                    dmem_wdata_d = 32'h0000_0000;
                    dmem_be_d    = 4'b0000;
                    instr_out_d  = instr_lat_q;
                    pc_out_d     = pc_lat_q;
                    wreg_out_d   = wreg_lat_q;
                    rw_out_d     = is_load_q & rw_lat_q;
                    wdata_out_d  = is_load_q ? ld_data_s : 32'h0000_0000;
                end else begin
                    state_d = WAIT;
                end
            end
            default: begin
                state_d    = IDLE;
                dmem_req_d = 1'b0;
            end
        endcase
    end

    // All state registers; asynchronous reset abandons any transaction
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q      <= IDLE;
            dmem_req_q   <= 1'b0;
            dmem_we_q    <= 1'b0;
            dmem_addr_q  <= 32'h0000_0000;
            dmem_wdata_q <= 32'h0000_0000;
            dmem_be_q    <= 4'b0000;
            op_q         <= 6'h00;
            off_q        <= 2'b00;
            is_load_q    <= 1'b0;
            rw_lat_q     <= 1'b0;
            wreg_lat_q   <= 5'd0;
            instr_lat_q  <= 32'h0000_0000;
            pc_lat_q     <= 32'h0000_0000;
            instr_out_q  <= 32'h0000_0000;
            pc_out_q     <= 32'h0000_0000;
            wdata_out_q  <= 32'h0000_0000;
            wreg_out_q   <= 5'd0;
            rw_out_q     <= 1'b0;
            addrerr_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            dmem_req_q   <= dmem_req_d;
            dmem_we_q    <= dmem_we_d;
            dmem_addr_q  <= dmem_addr_d;
            dmem_wdata_q <= dmem_wdata_d;
            dmem_be_q    <= dmem_be_d;
            op_q         <= op_d;
            off_q        <= off_d;
            is_load_q    <= is_load_d;
            rw_lat_q     <= rw_lat_d;
            wreg_lat_q   <= wreg_lat_d;
            instr_lat_q  <= instr_lat_d;
            pc_lat_q     <= pc_lat_d;
            instr_out_q  <= instr_out_d;
            pc_out_q     <= pc_out_d;
            wdata_out_q  <= wdata_out_d;
            wreg_out_q   <= wreg_out_d;
            rw_out_q     <= rw_out_d;
            addrerr_q    <= addrerr_d;
        end
    end

    assign dmem_req           = dmem_req_q;
    assign dmem_we            = dmem_we_q;
    assign dmem_addr          = dmem_addr_q;
    assign dmem_wdata         = dmem_wdata_q;
    assign dmem_be            = dmem_be_q;
    assign Instr1_OUT         = instr_out_q;
    assign Instr1_PC_OUT      = pc_out_q;
    assign WriteData1_OUT     = wdata_out_q;
    assign WriteRegister1_OUT = wreg_out_q;
    assign RegWrite1_OUT      = rw_out_q;
    assign AddrErr_OUT        = addrerr_q;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios followed by random
// operations, all checked against a byte-oriented reference model.
module tb_mem_stage;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [31:0] Instr1_IN, Instr1_PC_IN, ALU_result1_IN, MemWriteData1_IN;
    logic [4:0]  WriteRegister1_IN;
    logic        RegWrite1_IN, MemRead1_IN, MemWrite1_IN;
    logic [5:0]  ALU_Control1_IN;
    logic        Stall_OUT, dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;
    logic        dmem_ack;
    logic [31:0] Instr1_OUT, Instr1_PC_OUT, WriteData1_OUT;
    logic [4:0]  WriteRegister1_OUT;
    logic        RegWrite1_OUT, AddrErr_OUT;

    int checks = 0;
    int errors = 0;

    mem_stage dut (
        .CLK(CLK), .RESET(RESET),
        .Instr1_IN(Instr1_IN), .Instr1_PC_IN(Instr1_PC_IN),
        .ALU_result1_IN(ALU_result1_IN), .WriteRegister1_IN(WriteRegister1_IN),
        .MemWriteData1_IN(MemWriteData1_IN), .RegWrite1_IN(RegWrite1_IN),
        .MemRead1_IN(MemRead1_IN), .MemWrite1_IN(MemWrite1_IN),
        .ALU_Control1_IN(ALU_Control1_IN), .Stall_OUT(Stall_OUT),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_rdata(dmem_rdata),
        .dmem_ack(dmem_ack), .Instr1_OUT(Instr1_OUT), .Instr1_PC_OUT(Instr1_PC_OUT),
        .WriteData1_OUT(WriteData1_OUT), .WriteRegister1_OUT(WriteRegister1_OUT),
        .RegWrite1_OUT(RegWrite1_OUT), .AddrErr_OUT(AddrErr_OUT)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        bit          mem;
        bit          err;
        bit          is_load;
        int          size;
        bit          sgn;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] addr;
    } exp_t;

    // Reference: access described as (size in bytes, byte offset, signedness)
    function automatic exp_t model(input logic rd, input logic wr, input logic [5:0] code,
                                   input logic [31:0] addr, input logic [31:0] data);
        exp_t e;
        int off, start, idx;
        off       = int'(addr[1:0]);
        e.mem     = rd | wr;
        e.is_load = rd & !wr;
        e.sgn     = 1'b0;
        if (wr) begin
            e.size = (code == 6'h28) ? 1 : (code == 6'h29) ? 2 : 4;
        end else begin
            if (code == 6'h20 || code == 6'h24) e.size = 1;
            else if (code == 6'h21 || code == 6'h25) e.size = 2;
            else e.size = 4;
            e.sgn = (code == 6'h20 || code == 6'h21);
        end
        e.err  = e.mem && ((rd && wr) || (off % e.size != 0));
        e.addr = addr & 32'hFFFF_FFFC;
        start  = (e.size == 4) ? 0 : off;
        for (int b = 0; b < 4; b++) begin
            e.be[3-b] = (b >= start) && (b < start + e.size);
            idx = e.size - 1 - (b % e.size);
            e.wdata[31-8*b -: 8] = data[8*idx +: 8];
        end
        return e;
    endfunction

    function automatic logic [31:0] model_load(input int size, input bit sgn,
                                               input logic [1:0] off, input logic [31:0] rdata);
        logic [31:0] mask, v;
        mask = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8*size)) - 32'd1);
        v = (rdata >> (8*(4 - int'(off) - size))) & mask;
        if (sgn && v[8*size-1]) v = v | ~mask;
        return v;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [5:0] code,
                         input logic [31:0] alu, input logic [31:0] data,
                         input logic rw, input logic [4:0] wreg,
                         input logic [31:0] instr, input logic [31:0] pc);
        MemRead1_IN       = rd;
        MemWrite1_IN      = wr;
        ALU_Control1_IN   = code;
        ALU_result1_IN    = alu;
        MemWriteData1_IN  = data;
        RegWrite1_IN      = rw;
        WriteRegister1_IN = wreg;
        Instr1_IN         = instr;
        Instr1_PC_IN      = pc;
    endtask

    // Present one instruction, play the memory for k cycles if needed, check WB
    task automatic run_op(input logic rd, input logic wr, input logic [5:0] code,
                          input logic [31:0] alu, input logic [31:0] data,
                          input logic rw, input logic [4:0] wreg,
                          input int k, input logic [31:0] rdata);
        exp_t e;
        logic [31:0] instr, pc;
        int stalls;
        instr = $urandom;
        pc    = $urandom;
        e = model(rd, wr, code, alu, data);
        drive(rd, wr, code, alu, data, rw, wreg, instr, pc);
        #1;
        check("req_low_at_issue", 32'(dmem_req), 32'd0);
        if (!e.mem) begin
            check("stall_alu", 32'(Stall_OUT), 32'd0);
            tick();
            check("alu_wdata", WriteData1_OUT, alu);
            check("alu_rw", 32'(RegWrite1_OUT), 32'(rw));
            check("alu_wreg", 32'(WriteRegister1_OUT), 32'(wreg));
            check("alu_instr", Instr1_OUT, instr);
            check("alu_pc", Instr1_PC_OUT, pc);
            check("alu_err", 32'(AddrErr_OUT), 32'd0);
        end else if (e.err) begin
            check("stall_err", 32'(Stall_OUT), 32'd0);
            tick();
            check("err_req", 32'(dmem_req), 32'd0);
            check("err_pulse", 32'(AddrErr_OUT), 32'd1);
            check("err_rw", 32'(RegWrite1_OUT), 32'd0);
            drive(1'b0, 1'b0, 6'h00, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 32'h0);
            tick();
            check("err_pulse_end", 32'(AddrErr_OUT), 32'd0);
            check("err_req2", 32'(dmem_req), 32'd0);
        end else begin
            stalls = Stall_OUT ? 1 : 0;
            tick();
            for (int i = 1; i <= k; i++) begin
                check("req_held", 32'(dmem_req), 32'd1);
                check("req_we", 32'(dmem_we), 32'(wr));
                check("req_addr", dmem_addr, e.addr);
                check("req_be", 32'(dmem_be), 32'(e.be));
                if (wr) check("req_wdata", dmem_wdata, e.wdata);
                check("bubble_rw", 32'(RegWrite1_OUT), 32'd0);
                check("bubble_err", 32'(AddrErr_OUT), 32'd0);
                dmem_ack   = (i == k);
                dmem_rdata = (i == k) ? rdata : $urandom;
                #1;
                if (Stall_OUT) stalls++;
                tick();
                dmem_ack = 1'b0;
            end
            check("stall_cycles", 32'(stalls), 32'(k));
            check("done_req", 32'(dmem_req), 32'd0);
            check("done_rw", 32'(RegWrite1_OUT), e.is_load ? 32'(rw) : 32'd0);
            check("done_wreg", 32'(WriteRegister1_OUT), 32'(wreg));
            check("done_instr", Instr1_OUT, instr);
            check("done_err", 32'(AddrErr_OUT), 32'd0);
            if (e.is_load)
                check("load_data", WriteData1_OUT,
                      model_load(e.size, e.sgn, alu[1:0], rdata));
        end
    endtask

    logic [5:0] codes [0:9];

    initial begin
        codes = '{6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B, 6'h00, 6'h3F};
        RESET = 1'b0;
        dmem_ack = 1'b0;
        dmem_rdata = 32'h0;
        drive(1'b0, 1'b0, 6'h00, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 32'h0);
        #1;
        check("rst_req", 32'(dmem_req), 32'd0);
        check("rst_stall", 32'(Stall_OUT), 32'd0);
        check("rst_wdata", WriteData1_OUT, 32'd0);
        check("rst_rw", 32'(RegWrite1_OUT), 32'd0);
        check("rst_be", 32'(dmem_be), 32'd0);
        repeat (2) @(posedge CLK);
        #3 RESET = 1'b1;
        tick();

        // ALU passthrough
        run_op(1'b0, 1'b0, 6'h00, 32'h1234_5678, 32'h0, 1'b1, 5'd8, 1, 32'h0);
        // SB at 0x1003, ack arriving on the fourth cycle of the request
        run_op(1'b0, 1'b1, 6'h28, 32'h0000_1003, 32'h0000_00AB, 1'b1, 5'd1, 4, 32'h0);
        // Load extension
        run_op(1'b1, 1'b0, 6'h20, 32'h0000_2001, 32'h0, 1'b1, 5'd2, 2, 32'h1180_3344);
        run_op(1'b1, 1'b0, 6'h24, 32'h0000_2001, 32'h0, 1'b1, 5'd3, 1, 32'h1180_3344);
        run_op(1'b1, 1'b0, 6'h21, 32'h0000_2002, 32'h0, 1'b1, 5'd4, 3, 32'h1234_8001);
        run_op(1'b1, 1'b0, 6'h23, 32'h0000_2000, 32'h0, 1'b1, 5'd5, 1, 32'h1180_3344);
        // Error cases
        run_op(1'b1, 1'b0, 6'h23, 32'h0000_3002, 32'h0, 1'b1, 5'd6, 1, 32'h0);
        run_op(1'b1, 1'b0, 6'h21, 32'h0000_3001, 32'h0, 1'b1, 5'd7, 1, 32'h0);
        run_op(1'b1, 1'b1, 6'h23, 32'h0000_3000, 32'h0, 1'b1, 5'd9, 1, 32'h0);
        // Back-to-back word loads, each acked in the first wait cycle
        run_op(1'b1, 1'b0, 6'h23, 32'h0000_0010, 32'h0, 1'b1, 5'd10, 1, 32'hCAFE_0010);
        run_op(1'b1, 1'b0, 6'h23, 32'h0000_0014, 32'h0, 1'b1, 5'd11, 1, 32'hCAFE_0014);

        // Reset while waiting for ack
        drive(1'b1, 1'b0, 6'h23, 32'h0000_0040, 32'h0, 1'b1, 5'd12, 32'h1, 32'h2);
        tick();
        check("wait_req", 32'(dmem_req), 32'd1);
        #2 RESET = 1'b0;
        #1;
        check("midrst_req", 32'(dmem_req), 32'd0);
        check("midrst_stall", 32'(Stall_OUT), 32'd0);
        check("midrst_addr", dmem_addr, 32'd0);
        check("midrst_rw", 32'(RegWrite1_OUT), 32'd0);
        check("midrst_instr", Instr1_OUT, 32'd0);
        drive(1'b0, 1'b0, 6'h00, 32'h0000_0055, 32'h0, 1'b1, 5'd3, 32'h0, 32'h0);
        dmem_ack   = 1'b1;
        dmem_rdata = 32'hDEAD_BEEF;
        #2 RESET = 1'b1;
        tick();
        dmem_ack = 1'b0;
        check("stray_ack_req", 32'(dmem_req), 32'd0);
        check("stray_ack_wdata", WriteData1_OUT, 32'h0000_0055);
        check("stray_ack_rw", 32'(RegWrite1_OUT), 32'd1);

        // Random mix
        for (int n = 0; n < 60; n++) begin
            logic rd, wr;
            int kind;
            kind = $urandom_range(0, 9);
            rd = (kind >= 2 && kind <= 5) || kind == 9;
            wr = (kind >= 6);
            run_op(rd, wr, codes[$urandom_range(0, 9)], $urandom, $urandom,
                   1'($urandom), 5'($urandom), $urandom_range(1, 4), $urandom);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
